// File: rtl/sram_frame_reader_pkg.sv
// Shared definitions for the display-side SRAM frame reader: raster defaults,
// controller state encodings and the RGB444 to 10-bit channel expansion.
package sram_frame_reader_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;

  localparam int unsigned ADDR_W = 20;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CHAN_W = 10;

  // Bus owner state: RD serves the display, WR issues one drawing-engine word,
  // TURN idles the bus so the SRAM and the controller never drive DQ together.
  typedef enum logic [1:0] {
    ST_RD   = 2'd0,
    ST_WR   = 2'd1,
    ST_TURN = 2'd2
  } state_e;

  // Four-bit colour nibble placed in the MSBs of a 10-bit DAC channel.
  function automatic logic [CHAN_W-1:0] expand4(input logic [3:0] nib);
    return {nib, 6'b00_0000};
  endfunction

endpackage

// File: rtl/sram_bus_drv.sv
// Registered SRAM pin driver: address, WE_N, OE_N and the DQ tri-state.
// The controller only hands over the next bus state; all pins change on the
// clock edge, and reset releases DQ and deasserts WE_N immediately.
module sram_bus_drv
  import sram_frame_reader_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  state_e            cmd_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic              sram_we_n_o,
  output logic              sram_oe_n_o,
  inout  wire  [DATA_W-1:0] sram_dq_io,
  output logic [11:0]       rd_rgb_o
);

  logic [ADDR_W-1:0] addr_q;
  logic              we_n_q;
  logic              oe_n_q;
  logic              dq_oe_q;
  logic [DATA_W-1:0] dq_out_q;

  // Pin registers loaded according to the state the controller enters next.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q   <= '0;
      we_n_q   <= 1'b1;
      oe_n_q   <= 1'b0;
      dq_oe_q  <= 1'b0;
      dq_out_q <= '0;
    end else begin
      unique case (cmd_i)
        ST_RD: begin
          addr_q  <= rd_addr_i;
          we_n_q  <= 1'b1;
          oe_n_q  <= 1'b0;
          dq_oe_q <= 1'b0;
        end
        ST_WR: begin
          addr_q   <= wr_addr_i;
          dq_out_q <= wr_data_i;
          we_n_q   <= 1'b0;
          oe_n_q   <= 1'b1;
          dq_oe_q  <= 1'b1;
        end
        default: begin
          // Turnaround: address held, nobody drives DQ.
          we_n_q  <= 1'b1;
          oe_n_q  <= 1'b1;
          dq_oe_q <= 1'b0;
        end
      endcase
    end
  end

  assign sram_dq_io  = dq_oe_q ? dq_out_q : 'z;
  assign sram_addr_o = addr_q;
  assign sram_we_n_o = we_n_q;
  assign sram_oe_n_o = oe_n_q;

  // Only the RGB444 field of a pixel word is ever consumed.
  assign rd_rgb_o = sram_dq_io[15:4];

endmodule

// File: rtl/sram_frame_reader.sv
// Display-side owner of the 1M x 16 pixel SRAM. Reads the pixel at {X,Y}
// for every VGA coordinate with a fixed two-cycle latency and grants single
// word writes from the drawing engine in blanking (or anywhere, if enabled).
module sram_frame_reader
  import sram_frame_reader_pkg::*;
#(
  parameter int unsigned H_ACTIVE     = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE     = V_ACTIVE_DEF,
  parameter bit          WR_IN_ACTIVE = 1'b0
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic [9:0]        iCoord_X,
  input  logic [9:0]        iCoord_Y,
  input  logic              iWr_Req,
  input  logic [ADDR_W-1:0] iWr_Addr,
  input  logic [DATA_W-1:0] iWr_Data,
  output logic              oWr_Ack,
  output logic [CHAN_W-1:0] oRed,
  output logic [CHAN_W-1:0] oGreen,
  output logic [CHAN_W-1:0] oBlue,
  output logic [ADDR_W-1:0] oSRAM_ADDR,
  inout  wire  [DATA_W-1:0] ioSRAM_DQ,
  output logic              oSRAM_WE_N,
  output logic              oSRAM_OE_N,
  output logic              oSRAM_CE_N,
  output logic              oSRAM_UB_N,
  output logic              oSRAM_LB_N
);

  state_e      state_q, state_d;
  logic        blank_now;
  logic        wr_grant;
  logic [11:0] rd_rgb;

  // Pipeline: stage 1 follows the address register, stage 2 the data
  // register, stage 3 is the RGB output register.
  logic        s1_valid_q, s1_blank_q;
  logic        s2_valid_q, s2_blank_q;
  logic [11:0] pix_q;
  logic [11:0] rgb_q;
  logic        ack_q;

  assign blank_now = (32'(iCoord_X) >= H_ACTIVE) || (32'(iCoord_Y) >= V_ACTIVE);
  assign wr_grant  = iWr_Req && (blank_now || WR_IN_ACTIVE);

  // Controller state register.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= ST_RD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: every write costs a WR and a TURN cycle before reads resume.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RD:   if (wr_grant) state_d = ST_WR;
      ST_WR:   state_d = ST_TURN;
      ST_TURN: state_d = ST_RD;
      default: state_d = ST_RD;
    endcase
  end

  sram_bus_drv u_bus (
    .clk_i       (iCLK),
    .rst_ni      (iRST_N),
    .cmd_i       (state_d),
    .rd_addr_i   ({iCoord_X, iCoord_Y}),
    .wr_addr_i   (iWr_Addr),
    .wr_data_i   (iWr_Data),
    .sram_addr_o (oSRAM_ADDR),
    .sram_we_n_o (oSRAM_WE_N),
    .sram_oe_n_o (oSRAM_OE_N),
    .sram_dq_io  (ioSRAM_DQ),
    .rd_rgb_o    (rd_rgb)
  );

  // Ack is high for exactly the cycle the write sits on the SRAM pins.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      ack_q <= 1'b0;
    end else begin
      ack_q <= (state_d == ST_WR);
    end
  end

  // Stage 1: tag the registered address as a real read and carry blanking.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      s1_valid_q <= 1'b0;
      s1_blank_q <= 1'b1;
    end else begin
      s1_valid_q <= (state_d == ST_RD);
      s1_blank_q <= blank_now;
    end
  end

  // Stage 2: sample DQ only for visible pixels actually read.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      s2_valid_q <= 1'b0;
      s2_blank_q <= 1'b1;
      pix_q      <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      s2_blank_q <= s1_blank_q;
      if (s1_valid_q && !s1_blank_q) begin
        pix_q <= rd_rgb;
      end
    end
  end

  // Stage 3: blank forces black, a stolen pixel repeats the last one shown.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      rgb_q <= '0;
    end else if (s2_blank_q) begin
      rgb_q <= '0;
    end else if (s2_valid_q) begin
      rgb_q <= pix_q;
    end
  end

  assign oWr_Ack    = ack_q;
  assign oRed       = expand4(rgb_q[11:8]);
  assign oGreen     = expand4(rgb_q[7:4]);
  assign oBlue      = expand4(rgb_q[3:0]);
  assign oSRAM_CE_N = 1'b0;
  assign oSRAM_UB_N = 1'b0;
  assign oSRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_sram_frame_reader.sv
// Directed bench for sram_frame_reader: one instance with writes limited to
// blanking, one allowed to steal visible cycles, each on its own SRAM model.
module tb_sram_frame_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  cx, cy;
  logic        req;
  logic [19:0] waddr;
  logic [15:0] wdata;

  logic        ack0, we0, oe0, ce0, ub0, lb0;
  logic [9:0]  r0, g0, b0;
  logic [19:0] addr0;
  wire  [15:0] dq0;

  logic        ack1, we1, oe1, ce1, ub1, lb1;
  logic [9:0]  r1, g1, b1;
  logic [19:0] addr1;
  wire  [15:0] dq1;

  logic [15:0] mem0 [0:1023];
  logic [15:0] mem1 [0:1023];

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  pullup pu0 (dq0);
  pullup pu1 (dq1);

  sram_frame_reader #(.H_ACTIVE(640), .V_ACTIVE(480), .WR_IN_ACTIVE(1'b0)) u_dut (
    .iCLK(clk), .iRST_N(rst_n), .iCoord_X(cx), .iCoord_Y(cy),
    .iWr_Req(req), .iWr_Addr(waddr), .iWr_Data(wdata), .oWr_Ack(ack0),
    .oRed(r0), .oGreen(g0), .oBlue(b0), .oSRAM_ADDR(addr0), .ioSRAM_DQ(dq0),
    .oSRAM_WE_N(we0), .oSRAM_OE_N(oe0), .oSRAM_CE_N(ce0),
    .oSRAM_UB_N(ub0), .oSRAM_LB_N(lb0)
  );

  sram_frame_reader #(.H_ACTIVE(640), .V_ACTIVE(480), .WR_IN_ACTIVE(1'b1)) u_dut_wa (
    .iCLK(clk), .iRST_N(rst_n), .iCoord_X(cx), .iCoord_Y(cy),
    .iWr_Req(req), .iWr_Addr(waddr), .iWr_Data(wdata), .oWr_Ack(ack1),
    .oRed(r1), .oGreen(g1), .oBlue(b1), .oSRAM_ADDR(addr1), .ioSRAM_DQ(dq1),
    .oSRAM_WE_N(we1), .oSRAM_OE_N(oe1), .oSRAM_CE_N(ce1),
    .oSRAM_UB_N(ub1), .oSRAM_LB_N(lb1)
  );

  wire [29:0] rgb0 = {r0, g0, b0};
  wire [29:0] rgb1 = {r1, g1, b1};

  // Model memory index: {x[4:0], y[4:0]} of the {x,y} address.
  wire [9:0] idx0 = {addr0[14:10], addr0[4:0]};
  wire [9:0] idx1 = {addr1[14:10], addr1[4:0]};

  function automatic logic [15:0] preload(input int unsigned i);
    case (i)
      0:       return 16'hF0A0;  // x0   y0
      32:      return 16'h1234;  // x1   y0
      64:      return 16'hABCD;  // x2   y0
      96:      return 16'h5670;  // x3   y0
      100:     return 16'h8880;  // x99  y100
      132:     return 16'h1110;  // x100 y100
      164:     return 16'h2220;  // x101 y100
      196:     return 16'h3330;  // x102 y100
      228:     return 16'h4440;  // x103 y100
      896:     return 16'hFFF0;  // x700 y0 (blank)
      160:     return 16'hEEE0;  // x5   y480 (blank)
      default: return 16'h0000;
    endcase
  endfunction

  assign dq0 = (rst_n && !oe0 && we0) ? mem0[idx0] : 'z;
  assign dq1 = (rst_n && !oe1 && we1) ? mem1[idx1] : 'z;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 1024; i++) mem0[i] <= preload(i);
    end else if (!we0) begin
      mem0[idx0] <= dq0;
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 1024; i++) mem1[i] <= preload(i);
    end else if (!we1) begin
      mem1[idx1] <= dq1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  localparam logic [29:0] PX_F0A0 = {10'h3C0, 10'h000, 10'h280};
  localparam logic [29:0] PX_1234 = {10'h040, 10'h080, 10'h0C0};
  localparam logic [29:0] PX_ABCD = {10'h280, 10'h2C0, 10'h300};
  localparam logic [29:0] PX_5670 = {10'h140, 10'h180, 10'h1C0};
  localparam logic [29:0] PX_8880 = {10'h200, 10'h200, 10'h200};
  localparam logic [29:0] PX_1110 = {10'h040, 10'h040, 10'h040};
  localparam logic [29:0] PX_2220 = {10'h080, 10'h080, 10'h080};
  localparam logic [29:0] PX_3330 = {10'h0C0, 10'h0C0, 10'h0C0};
  localparam logic [29:0] PX_4440 = {10'h100, 10'h100, 10'h100};

  logic [29:0] exp_sweep [4];
  logic [29:0] exp_line  [5];
  int ack_x, n_ack, overlap, n_ack1;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_sweep = '{PX_F0A0, PX_1234, PX_ABCD, PX_5670};
    exp_line  = '{PX_8880, PX_1110, PX_2220, PX_3330, PX_4440};

    rst_n = 1'b0; cx = '0; cy = '0; req = 1'b0; waddr = '0; wdata = '0;
    repeat (3) tick();

    // Reset state.
    chk("rst_we_n", we0, 1);
    chk("rst_oe_n", oe0, 0);
    chk("rst_addr", addr0, 0);
    chk("rst_dq_released", dq0, 16'hFFFF);
    chk("rst_ack", ack0, 0);
    chk("rst_rgb", rgb0, 0);
    chk("tied_ce_ub_lb", {ce0, ub0, lb0}, 0);
    rst_n = 1'b1;

    // Read sweep X=0..5, Y=0: pixel for X=i appears two edges after its address.
    for (int i = 0; i < 6; i++) begin
      cx = 10'(i);
      tick();
      if (i == 1) chk("rd_addr_x1", addr0, 20'h00400);
      if (i >= 2) chk("sweep_rgb", rgb0, exp_sweep[i-2]);
    end

    // Blank pixels are black even though the SRAM holds non-zero data.
    cx = 10'd700; cy = 10'd0;
    repeat (3) tick();
    chk("hblank_rgb", rgb0, 0);
    cx = 10'd5; cy = 10'd480;
    repeat (3) tick();
    chk("vblank_rgb", rgb0, 0);

    // Write granted in horizontal blanking.
    cx = 10'd700; cy = 10'd0;
    waddr = {10'd80, 10'd200}; wdata = 16'hFFFF; req = 1'b1;
    tick();
    chk("wr_we_n", we0, 0);
    chk("wr_oe_n", oe0, 1);
    chk("wr_addr", addr0, 20'h140C8);
    chk("wr_dq", dq0, 16'hFFFF);
    chk("wr_ack", ack0, 1);
    req = 1'b0;
    tick();
    chk("turn_we_n", we0, 1);
    chk("turn_oe_n", oe0, 1);
    chk("turn_ack", ack0, 0);
    tick();
    chk("back_rd_oe_n", oe0, 0);
    chk("back_rd_ack", ack0, 0);
    chk("mem_written", mem0[520], 16'hFFFF);

    // Distinct data so driven vs released DQ can be told apart.
    waddr = {10'd81, 10'd200}; wdata = 16'h1230; req = 1'b1;
    tick();
    chk("wr2_dq", dq0, 16'h1230);
    req = 1'b0;
    tick();
    chk("turn_dq_released", dq0, 16'hFFFF);
    tick();

    // Visible-region request with writes confined to blanking.
    cy = 10'd100; waddr = {10'd80, 10'd200}; wdata = 16'hFFFF; req = 1'b1;
    ack_x = 0; n_ack = 0;
    for (int x = 97; x <= 645; x++) begin
      cx = 10'(x);
      tick();
      if (ack0) begin
        n_ack++;
        if (ack_x == 0) ack_x = x;
        req = 1'b0;
      end
      if (x >= 101 && x <= 105) chk("line_rgb", rgb0, exp_line[x-101]);
    end
    chk("blank_only_ack_x", ack_x, 640);
    chk("blank_only_ack_n", n_ack, 1);

    // Cycle stealing in the visible region on the second instance.
    req = 1'b0; cy = 10'd100;
    for (int x = 97; x <= 106; x++) begin
      cx = 10'(x);
      if (x == 100) req = 1'b1;
      tick();
      if (x == 100) begin
        chk("steal_ack", ack1, 1);
        chk("no_steal_ack", ack0, 0);
        req = 1'b0;
      end
      if (x == 101) chk("steal_ack_once", ack1, 0);
      if (x == 102) chk("steal_px100_rpt", rgb1, PX_8880);
      if (x == 103) chk("steal_px101_rpt", rgb1, PX_8880);
      if (x == 104) chk("steal_px102", rgb1, PX_3330);
      if (x == 105) chk("steal_px103", rgb1, PX_4440);
      if (x == 102) chk("no_steal_px100", rgb0, PX_1110);
    end

    // Continuous request in blanking: WR, TURN, RD cadence.
    cx = 10'd700; cy = 10'd0; req = 1'b1; overlap = 0; n_ack1 = 0;
    for (int k = 0; k < 9; k++) begin
      tick();
      chk("burst_ack", ack0, (k % 3 == 0) ? 1 : 0);
      if (!we0 && !oe0) overlap++;
      if (!we1 && !oe1) overlap++;
      if (ack1) n_ack1++;
    end
    chk("we_oe_overlap", overlap, 0);
    chk("burst_ack_wa_n", n_ack1, 3);
    req = 1'b0;
    repeat (2) tick();

    // Reset asserted in the middle of a WR cycle.
    waddr = {10'd3, 10'd3}; wdata = 16'h0000; req = 1'b1;
    tick();
    chk("pre_rst_we_n", we0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_we_n", we0, 1);
    chk("arst_dq_released", dq0, 16'hFFFF);
    chk("arst_ack", ack0, 0);
    chk("arst_oe_n", oe0, 0);
    req = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_ack", ack0, 0);
    req = 1'b1;
    tick();
    chk("post_rst_rd_grant", ack0, 1);
    req = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
